seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display.

---
 rtl/seg_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg_scan_driver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: shadowed hex value, one digit per
// refresh slot, 0-F decode, decimal points, leading-zero blanking and anode dead time.
module seg_scan_driver #(
  parameter  int DIGITS      = 4,
  parameter  int CLK_DIV     = 50000,
  parameter  int SEG_ACT_LOW = 1,
  parameter  int AN_ACT_LOW  = 1,
  localparam int IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                blank_lz,
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic [DIGITS-1:0]   an_out,
  output logic [IW-1:0]       digit_idx
);

  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]  IDX_MAX = IW'(DIGITS - 1);
  localparam logic           SEG_OFF = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic           AN_OFF  = (AN_ACT_LOW != 0) ? 1'b1 : 1'b0;

  logic [4*DIGITS-1:0] shadow_r;
  logic [DIGITS-1:0]   dp_sh_r;
  logic [CW-1:0]       cnt_r;
  logic [IW-1:0]       idx_r;

  logic [3:0]          nib_s;
  logic                dp_sel_s;
  logic                blank_s;
  logic                zero_above_s;
  logic                lit_s;
  logic [DIGITS-1:0]   sel_s;
  logic [6:0]          seg_nx_s;
  logic [DIGITS-1:0]   an_nx_s;
  logic                dp_nx_s;

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1111110;
      4'h1:    pat = 7'b0110000;
      4'h2:    pat = 7'b1101101;
      4'h3:    pat = 7'b1111001;
      4'h4:    pat = 7'b0110011;
      4'h5:    pat = 7'b1011011;
      4'h6:    pat = 7'b1011111;
      4'h7:    pat = 7'b1110000;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1111011;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b0011111;
      4'hC:    pat = 7'b1001110;
      4'hD:    pat = 7'b0111101;
      4'hE:    pat = 7'b1001111;
      4'hF:    pat = 7'b1000111;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  // Shadow registers capture the display value only on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= {(4*DIGITS){1'b0}};
      dp_sh_r  <= {DIGITS{1'b0}};
    end else if (load) begin
      shadow_r <= value;
      dp_sh_r  <= dp_in;
    end else begin
      shadow_r <= shadow_r;
      dp_sh_r  <= dp_sh_r;
    end
  end

  // Refresh prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= {IW{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= (idx_r == IDX_MAX) ? {IW{1'b0}} : idx_r + 1'b1;
    end else begin
      cnt_r <= cnt_r + 1'b1;
      idx_r <= idx_r;
    end
  end

  // Select the scanned nibble and decide blanking; zero_above_s walks from the top digit down.
  always_comb begin
    nib_s        = 4'h0;
    dp_sel_s     = 1'b0;
    blank_s      = 1'b0;
    zero_above_s = 1'b1;
    sel_s        = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (shadow_r[4*i +: 4] == 4'h0) & ~dp_sh_r[i];
      sel_s[i]     = (IW'(i) == idx_r);
      nib_s        = sel_s[i] ? shadow_r[4*i +: 4] : nib_s;
      dp_sel_s     = sel_s[i] ? dp_sh_r[i] : dp_sel_s;
      blank_s      = sel_s[i] ? (blank_lz & zero_above_s & (i != 0)) : blank_s;
    end
    lit_s    = ~blank_s & (cnt_r != {CW{1'b0}});
    seg_nx_s = blank_s ? 7'b0000000 : hex_decode(nib_s);
    an_nx_s  = lit_s ? sel_s : {DIGITS{1'b0}};
    dp_nx_s  = lit_s & dp_sel_s;
  end

  // Registered pin drivers with board polarity applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= {7{SEG_OFF}};
      dp_out  <= SEG_OFF;
      an_out  <= {DIGITS{AN_OFF}};
    end else begin
      seg_out <= (SEG_ACT_LOW != 0) ? ~seg_nx_s : seg_nx_s;
      dp_out  <= (SEG_ACT_LOW != 0) ? ~dp_nx_s : dp_nx_s;
      an_out  <= (AN_ACT_LOW != 0) ? ~an_nx_s : an_nx_s;
    end
  end

  assign digit_idx = idx_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a slot/position
// reference model derived from the elapsed clock count since reset.
module tb_seg_scan_driver;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;

  int          checks   = 0;
  int          failures = 0;
  int          k;
  logic [15:0] sh_m;
  logic [3:0]  dp_m;
  logic [3:0]  last_an_m;
  logic [6:0]  seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg_scan_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict outputs from elapsed cycles k and the model shadow, then compare.
  task automatic step();
    int         idx;
    int         pos;
    logic       blank;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    idx   = (k / CLK_DIV) % DIGITS;
    pos   = k % CLK_DIV;
    blank = blank_lz && (idx > 0) && ((sh_m >> (4*idx)) == 16'h0) && ((dp_m >> idx) == 4'h0);
    e_seg = blank ? 7'h7F : ~seg_tbl[sh_m[4*idx +: 4]];
    e_an  = (blank || pos == 0) ? 4'hF : ~(4'b0001 << idx);
    e_dp  = !(dp_m[idx] && !blank && pos != 0);
    @(posedge clk);
    if (load) begin
      sh_m = value;
      dp_m = dp_in;
    end
    k++;
    #1;
    last_an_m = e_an;
    check_eq("seg", {25'd0, seg_out}, {25'd0, e_seg});
    check_eq("an", {28'd0, an_out}, {28'd0, e_an});
    check_eq("dp", {31'd0, dp_out}, {31'd0, e_dp});
    check_eq("idx", {30'd0, digit_idx}, 32'((k / CLK_DIV) % DIGITS));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must go inactive at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_an", {28'd0, an_out}, 32'hF);
    check_eq("rst_seg", {25'd0, seg_out}, 32'h7F);
    check_eq("rst_dp", {31'd0, dp_out}, 32'h1);
    check_eq("rst_idx", {30'd0, digit_idx}, 32'h0);
    #2 rst = 1'b0;
    k    = 0;
    sh_m = 16'h0;
    dp_m = 4'h0;
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    logic [15:0] mask;
    int          found;
    rst = 1'b1; value = 16'h0; dp_in = 4'h0; load = 1'b0; blank_lz = 1'b0;
    k = 0; sh_m = 16'h0; dp_m = 4'h0; last_an_m = 4'hF;
    #1;
    check_eq("por_an", {28'd0, an_out}, 32'hF);
    check_eq("por_seg", {25'd0, seg_out}, 32'h7F);
    @(negedge clk);
    rst = 1'b0;

    load_pulse(16'h12AF, 4'h0);
    run(34);

    blank_lz = 1'b1;
    load_pulse(16'h0050, 4'h0);
    run(20);
    load_pulse(16'h0000, 4'h0);
    run(20);
    load_pulse(16'h0005, 4'b0100);
    run(20);

    load_pulse(16'h1111, 4'h0);
    run(6);
    value = 16'h2222;
    run(16);
    load_pulse(16'h2222, 4'h0);
    run(10);

    // Load coinciding with the prescaler tick.
    while ((k % CLK_DIV) != CLK_DIV - 1) step();
    load_pulse(16'h9876, 4'b1010);
    run(20);

    // Reset while digit 2 is lit.
    blank_lz = 1'b0;
    load_pulse(16'h4321, 4'h0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (last_an_m == 4'b1011) found = 1;
    end
    check_eq("find_d2", found, 1);
    do_reset();
    run(12);

    for (int i = 0; i < 600; i++) begin
      mask  = 16'hFFFF >> (4 * $urandom_range(0, 4));
      value = 16'($urandom) & mask;
      dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      step();
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
